// File: rtl/cmp16_pkg.sv
// Shared types for the comparator arbiter: FSM encoding, operand width and
// the three-flag compare result.
package cmp16_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

endpackage

// File: rtl/cmp16_core.sv
// Combinational 16-bit magnitude comparator producing a one-hot eq/gt/lt
// result, unsigned or two's complement depending on SIGNED.
module cmp16_core
  import cmp16_pkg::*;
#(
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output cmp_res_t          res
);

  logic [DATA_W-1:0] w_ka;
  logic [DATA_W-1:0] w_kb;

  // Flipping the sign bit maps two's complement order onto unsigned order,
  // so a single unsigned comparator serves both modes.
  assign w_ka = {a[DATA_W-1] ^ SIGNED, a[DATA_W-2:0]};
  assign w_kb = {b[DATA_W-1] ^ SIGNED, b[DATA_W-2:0]};

  always_comb begin
    res    = '0;
    res.eq = (w_ka == w_kb);
    res.gt = (w_ka > w_kb);
    res.lt = (w_ka < w_kb);
  end

endmodule

// File: rtl/cmp16_arbiter.sv
// Round-robin arbiter that feeds N requesters through one shared 16-bit
// comparator and returns eq/gt/lt with the requester ID on a response channel.
module cmp16_arbiter
  import cmp16_pkg::*;
#(
  parameter int N      = 4,
  parameter int IDW    = 2,
  parameter int SIGNED = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  input  logic [DATA_W*N-1:0] req_a,
  input  logic [DATA_W*N-1:0] req_b,
  output logic [N-1:0]        req_ready,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_eq,
  output logic                rsp_gt,
  output logic                rsp_lt,
  output logic                busy
);

  state_t            r_state;
  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    r_gnt_id;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_rsp_valid;
  logic [IDW-1:0]    r_rsp_id;
  cmp_res_t          r_res;

  logic [DATA_W-1:0] w_a [N];
  logic [DATA_W-1:0] w_b [N];
  logic [N-1:0]      w_grant;
  logic [IDW-1:0]    w_gnt_idx;
  logic [IDW:0]      w_sum;
  logic              w_found;
  logic [IDW-1:0]    w_next_ptr;
  cmp_res_t          w_core_res;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign w_a[gi] = req_a[DATA_W*gi +: DATA_W];
    assign w_b[gi] = req_b[DATA_W*gi +: DATA_W];
  end

  // First valid requester at or after rr_ptr, wrapping modulo N.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(N)) begin
        w_sum = w_sum - (IDW+1)'(N);
      end
      if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[IDW-1:0];
      end
    end
    if (w_found) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign w_next_ptr = (w_gnt_idx == IDW'(N-1)) ? '0 : w_gnt_idx + 1'b1;
  assign req_ready  = (rst_n && r_state == IDLE) ? w_grant : '0;

  cmp16_core #(
    .SIGNED (SIGNED != 0)
  ) u_core (
    .a   (r_op_a),
    .b   (r_op_b),
    .res (w_core_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_gnt_id    <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_res       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_op_a   <= w_a[w_gnt_idx];
            r_op_b   <= w_b[w_gnt_idx];
            r_gnt_id <= w_gnt_idx;
            r_rr_ptr <= w_next_ptr;
            r_state  <= CMP;
          end
        end
        CMP: begin
          r_res       <= w_core_res;
          r_rsp_id    <= r_gnt_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          // rsp_id is left holding the last ID; only valid and flags clear.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_res       <= '0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_eq    = r_res.eq;
  assign rsp_gt    = r_res.gt;
  assign rsp_lt    = r_res.lt;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cmp16_arbiter.sv
// Directed bench for cmp16_arbiter: an unsigned and a signed instance share
// stimulus; a scoreboard predicts each response at request handshake time.
module tb_cmp16_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [16*N-1:0]   req_a;
  logic [16*N-1:0]   req_b;
  logic              rsp_ready;

  logic [N-1:0]      u_req_ready, s_req_ready;
  logic              u_rsp_valid, s_rsp_valid;
  logic [IDW-1:0]    u_rsp_id, s_rsp_id;
  logic              u_eq, u_gt, u_lt, s_eq, s_gt, s_lt;
  logic              u_busy, s_busy;

  typedef struct {
    logic [IDW-1:0] id;
    logic [2:0]     fu;
    logic [2:0]     fs;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cmp16_arbiter #(.N(N), .IDW(IDW), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(u_req_ready), .rsp_valid(u_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(u_rsp_id), .rsp_eq(u_eq), .rsp_gt(u_gt), .rsp_lt(u_lt), .busy(u_busy)
  );

  cmp16_arbiter #(.N(N), .IDW(IDW), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(s_rsp_id), .rsp_eq(s_eq), .rsp_gt(s_gt), .rsp_lt(s_lt), .busy(s_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b, input bit sgn);
    if (sgn) return {$signed(a) == $signed(b), $signed(a) > $signed(b), $signed(a) < $signed(b)};
    return {a == b, a > b, a < b};
  endfunction

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    g = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (u_req_ready != '0) begin
        g = u_req_ready;
        break;
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rsp_valid"}, 32'(u_rsp_valid), 32'd0);
    check({tag, "_flags"},     32'({u_eq, u_gt, u_lt, s_eq, s_gt, s_lt}), 32'd0);
    check({tag, "_rsp_id"},    32'(u_rsp_id), 32'd0);
    check({tag, "_busy"},      32'({u_busy, s_busy}), 32'd0);
    check({tag, "_req_ready"}, 32'(u_req_ready), 32'd0);
  endtask

  // Monitor: predict on request handshake, compare on response handshake.
  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (rst_n === 1'b1) begin
      check("req_ready_onehot0", 32'($onehot0(u_req_ready)), 32'd1);
      if (|(req_valid & u_req_ready)) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (u_req_ready[i]) idx = i;
        e.id = IDW'(idx);
        e.fu = model(req_a[16*idx +: 16], req_b[16*idx +: 16], 1'b0);
        e.fs = model(req_a[16*idx +: 16], req_b[16*idx +: 16], 1'b1);
        sb.push_back(e);
      end
      if (u_rsp_valid) begin
        check("flags_onehot_u", 32'($countones({u_eq, u_gt, u_lt})), 32'd1);
        check("flags_onehot_s", 32'($countones({s_eq, s_gt, s_lt})), 32'd1);
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            check("rsp_pending", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("rsp_id_u",    32'(u_rsp_id), 32'(e.id));
            check("flags_u",     32'({u_eq, u_gt, u_lt}), 32'(e.fu));
            check("rsp_valid_s", 32'(s_rsp_valid), 32'd1);
            check("rsp_id_s",    32'(s_rsp_id), 32'(e.id));
            check("flags_s",     32'({s_eq, s_gt, s_lt}), 32'(e.fs));
          end
        end
      end else begin
        check("flags_idle_u", 32'({u_eq, u_gt, u_lt}), 32'd0);
      end
    end
  end

  initial begin
    logic [N-1:0] g;
    rst_n = 1'b0; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("ready_in_reset", 32'(u_req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;

    // Single request from requester 1
    set_op(1, 16'h1234, 16'h1234);
    req_valid = 4'b0010;
    @(negedge clk);
    check("single_ready", 32'(u_req_ready), 32'b0010);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("single_cmp_busy", 32'(u_busy), 32'd1);
    check("single_cmp_rsp_valid", 32'(u_rsp_valid), 32'd0);
    @(negedge clk);
    check("single_rsp_valid", 32'(u_rsp_valid), 32'd1);
    check("single_rsp_id", 32'(u_rsp_id), 32'd1);
    check("single_flags", 32'({u_eq, u_gt, u_lt}), 32'b100);
    @(negedge clk);
    check("single_back_idle", 32'({u_busy, u_rsp_valid}), 32'd0);

    // Round-robin from reset, all requesters valid
    @(posedge clk); #1 rst_n = 1'b0; sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    set_op(0, 16'h0005, 16'h0009);
    set_op(1, 16'hFFFF, 16'h0001);
    set_op(2, 16'h0007, 16'h0007);
    set_op(3, 16'h8000, 16'h7FFF);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check("rr_grant", 32'(g), 32'(1 << (k % N)));
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk); #1;

    // Backpressure on requester 2 while requester 0 waits
    rsp_ready = 1'b0;
    set_op(0, 16'h0003, 16'h0002);
    req_valid = 4'b0101;
    wait_grant(g);
    check("bp_grant", 32'(g), 32'b0100);
    @(posedge clk); #1 req_valid = 4'b0001;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(u_rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(u_rsp_id), 32'd2);
      check("bp_flags", 32'({u_eq, u_gt, u_lt}), 32'b100);
      check("bp_req_ready", 32'(u_req_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_grant", 32'(u_req_ready), 32'b0001);
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk); #1;

    // Sign mode on requester 1
    rsp_ready = 1'b0;
    set_op(1, 16'h8000, 16'h0001);
    req_valid = 4'b0010;
    wait_grant(g);
    check("sign_grant", 32'(g), 32'b0010);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("sign_unsigned_gt", 32'({u_eq, u_gt, u_lt}), 32'b010);
    check("sign_signed_lt", 32'({s_eq, s_gt, s_lt}), 32'b001);
    @(posedge clk); #1 rsp_ready = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Reset while holding a response in RESP
    rsp_ready = 1'b0;
    set_op(3, 16'h0001, 16'h0002);
    req_valid = 4'b1000;
    wait_grant(g);
    check("rstmid_grant", 32'(g), 32'b1000);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_in_resp", 32'(u_rsp_valid), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0; sb.delete();
    @(negedge clk);
    @(negedge clk);
    check_cleared("rstmid");
    @(posedge clk); #1 rst_n = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rstmid_no_rsp", 32'(u_rsp_valid), 32'd0);
    end

    // Operand change after grant must not affect the result
    set_op(0, 16'h0005, 16'h0010);
    req_valid = 4'b0001;
    wait_grant(g);
    check("opchg_grant", 32'(g), 32'b0001);
    @(posedge clk); #1;
    set_op(0, 16'hFFFF, 16'h0010);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("opchg_flags", 32'({u_eq, u_gt, u_lt}), 32'b001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp16_arbiter.md
Name: cmp16_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit magnitude comparator core among N requesters.
- Each requester presents an operand pair over a valid/ready channel.
- The block grants one requester, captures its operands, runs one compare and returns eq/gt/lt plus the requester ID on a single response channel with valid/ready backpressure.
- Sits between client blocks needing occasional compares and the shared comparator, so only one comparator instance exists in the design.

Parameters:
- N, 4, number of requesters (2..16).
- IDW, 2, width of the requester ID; must satisfy 2**IDW >= N.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  N  per-requester request valid.
- req_a  input  16*N  operand A; requester i uses bits [16*i+15:16*i].
- req_b  input  16*N  operand B; same packing as req_a.
- req_ready  output  N  per-requester accept; at most one bit high.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_id  output  IDW  index of the requester the result belongs to.
- rsp_eq  output  1  A == B.
- rsp_gt  output  1  A > B.
- rsp_lt  output  1  A < B.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is synchronous, on a clk edge while rst_n = 0:
  - state goes to IDLE and rr_ptr goes to 0;
  - rsp_valid, rsp_eq, rsp_gt, rsp_lt, rsp_id and busy all go to 0;
  - req_ready reads 0 while rst_n = 0;
  - an in-flight or held operation is discarded, with no response issued afterwards.
- FSM states are IDLE, CMP and RESP.
- IDLE:
  - req_ready is combinational: one-hot on the first i with req_valid[i], searching from rr_ptr upward modulo N.
  - A handshake occurs when req_valid[i] and req_ready[i] are both high. At the clock edge the block captures op_a/op_b, sets gnt_id = i, sets rr_ptr = (i+1) mod N and moves to CMP.
  - With no valid requests, req_ready = 0 and the block stays in IDLE.
- CMP:
  - req_ready = 0.
  - The comparator core evaluates the captured operands. The result registers and rsp_id are loaded, rsp_valid is set to 1, and the block moves to RESP.
- RESP:
  - req_ready = 0.
  - rsp_valid, rsp_id and the flags hold stable until rsp_ready = 1.
  - On the cycle of the rsp_ready handshake, rsp_valid and the flags go to 0 at the edge and the block returns to IDLE.
  - There is no accept in the same cycle as the response handshake.
- Latency: request accepted at edge T, rsp_valid high after edge T+1; minimum throughput is one compare per 3 cycles.
- Flags:
  - exactly one of eq/gt/lt is high whenever rsp_valid = 1;
  - all three are 0 whenever rsp_valid = 0.
- SIGNED = 1 treats operands as two's complement, so 16'h8000 is less than 16'h0001.
- A requester may drop req_valid before it is granted without error. Once granted, its captured operands are used regardless of later changes on req_a/req_b.
- Fairness: a requester that holds req_valid continuously is granted within N grants.
- rr_ptr wraps from N-1 to 0.
- busy = (state != IDLE).

Decomposition:
- Package cmp16_pkg holds:
  - the state encoding enum (IDLE, CMP, RESP);
  - the operand width constant DATA_W = 16;
  - a result struct {eq, gt, lt}.
- One sub-module, cmp16_core: purely combinational, parameterised by SIGNED, inputs a/b, outputs the result struct.
- The round-robin priority search stays inline in cmp16_arbiter.

Test Plan:
- Single request: req_valid = 4'b0010 with a = 16'h1234, b = 16'h1234 -> req_ready = 4'b0010; 2 cycles later rsp_valid = 1, rsp_id = 1, eq = 1, gt = 0, lt = 0.
- Round-robin: all four valid from reset -> grants in order 0, 1, 2, 3, 0, and rsp_id follows the same sequence.
- Backpressure: rsp_ready = 0 for 5 cycles during RESP -> rsp_valid and rsp_id/flags stable, req_ready = 0 throughout; rsp_ready = 1 -> return to IDLE, next grant on the following cycle.
- Sign mode: a = 16'h8000, b = 16'h0001 -> SIGNED = 0 gives gt = 1; SIGNED = 1 gives lt = 1.
- Reset mid-operation: rst_n = 0 for 1 cycle while in RESP -> all outputs 0 after the edge, and no response for the discarded request.
- Operand change after grant: req_a changes from 16'h0005 to 16'hFFFF the cycle after accept, with b = 16'h0010 -> result lt = 1, computed from the captured value.
